// File: rtl/face_color_classifier_pkg.sv
// rtl/face_color_classifier_pkg.sv - shared state encodings and facelet color codes
package face_color_classifier_pkg;

    localparam int NUM_FACELETS = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] COLOR_WHITE   = 3'd0;
    localparam logic [2:0] COLOR_YELLOW  = 3'd1;
    localparam logic [2:0] COLOR_RED     = 3'd2;
    localparam logic [2:0] COLOR_ORANGE  = 3'd3;
    localparam logic [2:0] COLOR_BLUE    = 3'd4;
    localparam logic [2:0] COLOR_GREEN   = 3'd5;
    localparam logic [2:0] COLOR_UNKNOWN = 3'd7;

    localparam logic [NUM_FACELETS-1:0] MASK_FULL = '1;

endpackage

// File: rtl/rgb565_color_classifier.sv
// rtl/rgb565_color_classifier.sv - combinational 5-bit RGB to facelet color code
module rgb565_color_classifier
    import face_color_classifier_pkg::*;
#(
    parameter int T_HI = 20,
    parameter int T_LO = 12,
    parameter int T_G  = 10
) (
    input  logic [4:0] r5_i,
    input  logic [4:0] g5_i,
    input  logic [4:0] b5_i,
    output logic [2:0] code_o
);

    localparam logic [4:0] HI    = 5'(T_HI);
    localparam logic [4:0] HI_P4 = 5'(T_HI + 4);
    localparam logic [4:0] HI_M4 = 5'(T_HI - 4);
    localparam logic [4:0] LO    = 5'(T_LO);
    localparam logic [4:0] GTH   = 5'(T_G);

    // First match wins; order matters where the rules overlap.
    always_comb begin
        code_o = COLOR_UNKNOWN;
        if (r5_i >= HI && g5_i >= HI && b5_i >= HI) begin
            code_o = COLOR_WHITE;
        end else if (r5_i >= HI && g5_i >= HI && b5_i < LO) begin
            code_o = COLOR_YELLOW;
        end else if (r5_i >= HI_P4 && g5_i >= GTH && g5_i < HI && b5_i < LO) begin
            code_o = COLOR_ORANGE;
        end else if (r5_i >= HI_M4 && g5_i < GTH && b5_i < LO) begin
            code_o = COLOR_RED;
        end else if (b5_i >= HI_M4 && r5_i < LO && b5_i > g5_i) begin
            code_o = COLOR_BLUE;
        end else if (g5_i >= HI_M4 && r5_i < LO && g5_i >= b5_i) begin
            code_o = COLOR_GREEN;
        end
    end

endmodule

// File: rtl/face_color_classifier.sv
// rtl/face_color_classifier.sv - captures 9 facelet pixels and classifies them one per cycle
module face_color_classifier
    import face_color_classifier_pkg::*;
#(
    parameter int T_HI = 20,
    parameter int T_LO = 12,
    parameter int T_G  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pixel_valid,
    input  logic [15:0] pixel,
    input  logic [1:0]  linha_addr,
    input  logic [1:0]  coluna_addr,
    input  logic [3:0]  rd_addr,
    output logic [2:0]  rd_color,
    output logic        busy,
    output logic        face_valid,
    output logic        pronto,
    output logic [1:0]  db_estado
);

    state_t                  state_q;
    logic [NUM_FACELETS-1:0] mask_q;
    logic [3:0]              idx_q;
    logic [14:0]             pix_q [NUM_FACELETS];
    logic [2:0]              color_q [NUM_FACELETS];
    logic [2:0]              rd_color_q;
    logic                    face_valid_q;
    logic                    pronto_q;

    logic                    wr_ok;
    logic [3:0]              wr_idx;
    logic [14:0]             cls_pix;
    logic [2:0]              cls_code;
    logic                    unused_g_lsb;

    // Green LSB is dropped: only the top five green bits feed the classifier.
    assign unused_g_lsb = pixel[5];
    assign wr_ok        = pixel_valid && (linha_addr != 2'd3) && (coluna_addr != 2'd3);
    assign wr_idx       = 4'(linha_addr) * 4'd3 + 4'(coluna_addr);
    assign cls_pix      = (idx_q < 4'(NUM_FACELETS)) ? pix_q[idx_q] : '0;

    rgb565_color_classifier #(
        .T_HI (T_HI),
        .T_LO (T_LO),
        .T_G  (T_G)
    ) u_cls (
        .r5_i   (cls_pix[14:10]),
        .g5_i   (cls_pix[9:5]),
        .b5_i   (cls_pix[4:0]),
        .code_o (cls_code)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            face_valid_q <= 1'b0;
            pronto_q     <= 1'b0;
            rd_color_q   <= COLOR_UNKNOWN;
            for (int i = 0; i < NUM_FACELETS; i++) begin
                color_q[i] <= COLOR_UNKNOWN;
            end
        end else begin
            pronto_q   <= 1'b0;
            rd_color_q <= (rd_addr < 4'(NUM_FACELETS)) ? color_q[rd_addr] : COLOR_UNKNOWN;
            // start beats any pixel strobe arriving in the same cycle.
            if (start) begin
                state_q      <= ST_COLLECT;
                mask_q       <= '0;
                idx_q        <= '0;
                face_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_COLLECT: begin
                        if (wr_ok) begin
                            pix_q[wr_idx]  <= {pixel[15:6], pixel[4:0]};
                            mask_q[wr_idx] <= 1'b1;
                        end
                        if (mask_q == MASK_FULL) begin
                            state_q <= ST_CLASSIFY;
                            idx_q   <= '0;
                        end
                    end
                    ST_CLASSIFY: begin
                        color_q[idx_q] <= cls_code;
                        if (idx_q == 4'(NUM_FACELETS - 1)) begin
                            state_q      <= ST_DONE;
                            face_valid_q <= 1'b1;
                            pronto_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_color   = rd_color_q;
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_CLASSIFY);
    assign face_valid = face_valid_q;
    assign pronto     = pronto_q;
    assign db_estado  = state_q;

endmodule
